// File: rtl/pmem_responder_if.sv
// Cache-to-memory line bus shared by the cache (master) and the pmem responder (slave).
interface pmem_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         proto_err;

    // Initiator side: issues requests, receives line data and completion.
    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp,
        input  proto_err
    );

    // Memory side: answers requests after a fixed latency.
    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp,
        output proto_err
    );
endinterface

// File: rtl/pmem_responder.sv
// Line-granular physical-memory responder: fixed-latency backing store for the
// LC-3b cache pmem port. One response pulse per accepted read/write line request.
module pmem_responder #(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    pmem_responder_if.slave  pmem
);
    localparam int unsigned LINE_W = 128;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DEPTH  = 1 << IDX_W;
    // Address bits that select the line; everything else is offset or alias.
    localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(((1 << IDX_W) - 1) << 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_q;
    logic [IDX_W-1:0]    idx_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   rdata_q;
    logic                resp_q;
    logic                perr_q;
    logic [LINE_W-1:0]   mem_q [DEPTH];

    logic                req_c;
    logic                both_c;
    logic                commit_c;
    logic [IDX_W-1:0]    idx_c;
    logic                unused_addr_c;

    // Request decode and write-commit strobe.
    always_comb begin
        req_c         = pmem.pmem_read | pmem.pmem_write;
        both_c        = pmem.pmem_read & pmem.pmem_write;
        idx_c         = pmem.pmem_address[IDX_W+3:4];
        commit_c      = (state_q == S_RESP) && wr_q;
        unused_addr_c = ^(pmem.pmem_address & ~IDX_MASK);
    end

    // Transaction FSM: accept in IDLE, count down in WAIT, pulse resp in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_c) begin
                        // Write takes priority when both requests are raised.
                        wr_q    <= pmem.pmem_write;
                        idx_q   <= idx_c;
                        wdata_q <= pmem.pmem_wdata;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= S_WAIT;
                        if (both_c) begin
                            perr_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // Requests are ignored here; a dropped request still completes.
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                        resp_q  <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    resp_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Line storage: not reset; a write lands on the edge leaving RESP, so a
    // reset during RESP discards it.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign pmem.pmem_rdata = rdata_q;
    assign pmem.pmem_resp  = resp_q;
    assign pmem.proto_err  = perr_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: a LATENCY=8 and a LATENCY=1 instance, each compared
// every cycle against a time-based transaction model, plus literal spot checks.
module tb_pmem_responder;
    logic         clk;
    logic         rst_a   [2];
    logic         rd_a    [2];
    logic         wr_a    [2];
    logic [15:0]  ad_a    [2];
    logic [127:0] wd_a    [2];
    logic [127:0] rdata_a [2];
    logic         resp_a  [2];
    logic         perr_a  [2];

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    localparam logic [127:0] LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] ALL_A  = {32{4'hA}};
    localparam logic [127:0] ALL_5  = {32{4'h5}};

    pmem_responder_if bus0 ();
    pmem_responder_if bus1 ();

    assign bus0.pmem_read    = rd_a[0];
    assign bus0.pmem_write   = wr_a[0];
    assign bus0.pmem_address = ad_a[0];
    assign bus0.pmem_wdata   = wd_a[0];
    assign rdata_a[0]        = bus0.pmem_rdata;
    assign resp_a[0]         = bus0.pmem_resp;
    assign perr_a[0]         = bus0.proto_err;

    assign bus1.pmem_read    = rd_a[1];
    assign bus1.pmem_write   = wr_a[1];
    assign bus1.pmem_address = ad_a[1];
    assign bus1.pmem_wdata   = wd_a[1];
    assign rdata_a[1]        = bus1.pmem_rdata;
    assign resp_a[1]         = bus1.pmem_resp;
    assign perr_a[1]         = bus1.proto_err;

    pmem_responder #(.LATENCY(8), .IDX_W(5)) u_dut8 (
        .clk  (clk),
        .rst  (rst_a[0]),
        .pmem (bus0)
    );

    pmem_responder #(.LATENCY(1), .IDX_W(5)) u_dut1 (
        .clk  (clk),
        .rst  (rst_a[1]),
        .pmem (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge index: the posedge that reads cyc==N is edge N.
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: acceptance at edge e when free, response on edge e+L,
    // write lands on edge e+L+1, next acceptance allowed from edge e+L+2.
    for (genvar g = 0; g < 2; g++) begin : g_m
        localparam int L = (g == 0) ? 8 : 1;
        int           resp_edge;
        int           next_ok;
        int           pend_idx;
        bit           pend_wr;
        logic [127:0] pend_data;
        logic [127:0] mm [32];
        bit           mv [32];
        logic         exp_resp;
        logic         exp_perr;
        logic         known;
        logic [127:0] exp_rdata;

        always @(posedge clk or posedge rst_a[g]) begin
            if (rst_a[g]) begin
                resp_edge <= -1;
                next_ok   <= 0;
                exp_resp  <= 1'b0;
                exp_perr  <= 1'b0;
                exp_rdata <= '0;
                known     <= 1'b1;
            end else begin
                exp_resp <= (cyc == resp_edge);
                if (cyc == resp_edge && !pend_wr) begin
                    exp_rdata <= mm[pend_idx];
                    known     <= mv[pend_idx];
                end
                if (resp_edge >= 0 && cyc == resp_edge + 1 && pend_wr) begin
                    mm[pend_idx] <= pend_data;
                    mv[pend_idx] <= 1'b1;
                end
                if (cyc >= next_ok && (rd_a[g] || wr_a[g])) begin
                    pend_wr   <= wr_a[g];
                    pend_idx  <= int'(ad_a[g][8:4]);
                    pend_data <= wd_a[g];
                    resp_edge <= cyc + L;
                    next_ok   <= cyc + L + 2;
                    if (rd_a[g] && wr_a[g]) exp_perr <= 1'b1;
                end
            end
        end
    end

    typedef struct {
        int           inst;
        int           cyc;
        bit           resp;
        bit           chk_data;
        logic [127:0] data;
        bit           chk_perr;
        bit           perr;
        string        name;
    } lit_t;

    lit_t lit_q [$];

    task automatic add_lit(input int inst, input int c, input bit resp, input bit chk_data,
                           input logic [127:0] data, input bit chk_perr, input bit perr,
                           input string name);
        lit_t e;
        e.inst = inst; e.cyc = c; e.resp = resp; e.chk_data = chk_data; e.data = data;
        e.chk_perr = chk_perr; e.perr = perr; e.name = name;
        lit_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input logic resp, input logic perr,
                            input logic [127:0] rdata, input logic e_resp, input logic e_perr,
                            input logic [127:0] e_rdata, input logic e_known);
        chk({tag, "_resp"}, 128'(resp), 128'(e_resp));
        chk({tag, "_perr"}, 128'(perr), 128'(e_perr));
        if (e_known) chk({tag, "_rdata"}, rdata, e_rdata);
    endtask

    // Single compare process: model on every cycle, then any literal due now.
    always @(negedge clk) begin
        chk_inst("L8", resp_a[0], perr_a[0], rdata_a[0],
                 g_m[0].exp_resp, g_m[0].exp_perr, g_m[0].exp_rdata, g_m[0].known);
        chk_inst("L1", resp_a[1], perr_a[1], rdata_a[1],
                 g_m[1].exp_resp, g_m[1].exp_perr, g_m[1].exp_rdata, g_m[1].known);
        foreach (lit_q[k]) begin
            if (lit_q[k].cyc == cyc) begin
                chk({lit_q[k].name, "_resp"}, 128'(resp_a[lit_q[k].inst]), 128'(lit_q[k].resp));
                if (lit_q[k].chk_data)
                    chk({lit_q[k].name, "_rdata"}, rdata_a[lit_q[k].inst], lit_q[k].data);
                if (lit_q[k].chk_perr)
                    chk({lit_q[k].name, "_perr"}, 128'(perr_a[lit_q[k].inst]), 128'(lit_q[k].perr));
            end
        end
    end

    // Present a request at a negedge; acc is the edge index that accepts it.
    task automatic xfer_start(input int inst, input bit r, input bit w, input logic [15:0] a,
                              input logic [127:0] d, output int acc);
        @(negedge clk);
        rd_a[inst] = r;
        wr_a[inst] = w;
        ad_a[inst] = a;
        wd_a[inst] = d;
        acc = cyc;
    endtask

    // Hold (or drop after one cycle) until pmem_resp, then release on that cycle.
    task automatic xfer_wait(input int inst, input bit drop);
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (drop && k == 0) begin
                rd_a[inst] = 1'b0;
                wr_a[inst] = 1'b0;
            end
            if (resp_a[inst] === 1'b1) begin
                rd_a[inst] = 1'b0;
                wr_a[inst] = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            $display("FAIL timeout inst %0d: pmem_resp never seen, required within 400 cycles", inst);
            $fatal(1);
        end
    endtask

    initial begin
        int a;
        int a1;
        for (int i = 0; i < 2; i++) begin
            rst_a[i] = 1'b1;
            rd_a[i]  = 1'b0;
            wr_a[i]  = 1'b0;
            ad_a[i]  = '0;
            wd_a[i]  = '0;
        end
        repeat (3) @(negedge clk);
        rst_a[0] = 1'b0;
        rst_a[1] = 1'b0;
        add_lit(0, cyc + 1, 1'b0, 1'b1, '0, 1'b1, 1'b0, "rst_vals8");
        add_lit(1, cyc + 1, 1'b0, 1'b1, '0, 1'b1, 1'b0, "rst_vals1");

        // Write then read, LATENCY=8.
        xfer_start(0, 1'b0, 1'b1, 16'h0040, LINE_A, a);
        add_lit(0, a + 8,  1'b0, 1'b0, '0, 1'b0, 1'b0, "wr_pre");
        add_lit(0, a + 9,  1'b1, 1'b0, '0, 1'b0, 1'b0, "wr_resp");
        add_lit(0, a + 10, 1'b0, 1'b0, '0, 1'b0, 1'b0, "wr_post");
        xfer_wait(0, 1'b0);
        xfer_start(0, 1'b1, 1'b0, 16'h0047, '0, a);
        add_lit(0, a + 9, 1'b1, 1'b1, LINE_A, 1'b1, 1'b0, "rd_0047");
        xfer_wait(0, 1'b0);

        // Aliasing and back-to-back acceptance.
        xfer_start(0, 1'b0, 1'b1, 16'h0010, ALL_A, a1);
        add_lit(0, a1 + 9, 1'b1, 1'b0, '0, 1'b0, 1'b0, "b2b_first");
        add_lit(0, a1 + 19, 1'b1, 1'b0, '0, 1'b0, 1'b0, "b2b_second");
        add_lit(0, a1 + 18, 1'b0, 1'b0, '0, 1'b0, 1'b0, "b2b_second_pre");
        xfer_wait(0, 1'b0);
        xfer_start(0, 1'b0, 1'b1, 16'h0210, ALL_5, a);
        xfer_wait(0, 1'b0);
        xfer_start(0, 1'b1, 1'b0, 16'h0010, '0, a);
        add_lit(0, a + 9, 1'b1, 1'b1, ALL_5, 1'b0, 1'b0, "alias_rd");
        xfer_wait(0, 1'b0);

        // Dropped request still completes and commits.
        xfer_start(0, 1'b0, 1'b1, 16'h0020, 128'h1, a);
        add_lit(0, a + 9, 1'b1, 1'b0, '0, 1'b0, 1'b0, "drop_resp");
        xfer_wait(0, 1'b1);
        xfer_start(0, 1'b1, 1'b0, 16'h0020, '0, a);
        add_lit(0, a + 9, 1'b1, 1'b1, 128'h1, 1'b0, 1'b0, "drop_rd");
        xfer_wait(0, 1'b0);

        // Read and write together: write wins, error is sticky.
        xfer_start(0, 1'b1, 1'b1, 16'h0030, 128'hDEAD, a);
        add_lit(0, a + 1, 1'b0, 1'b0, '0, 1'b1, 1'b1, "perr_rise");
        add_lit(0, a + 9, 1'b1, 1'b1, 128'h1, 1'b1, 1'b1, "perr_resp");
        xfer_wait(0, 1'b0);
        xfer_start(0, 1'b1, 1'b0, 16'h0030, '0, a);
        add_lit(0, a + 9, 1'b1, 1'b1, 128'hDEAD, 1'b1, 1'b1, "perr_rd");
        xfer_wait(0, 1'b0);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        @(posedge clk);
        #1;
        rst_a[0] = 1'b1;
        add_lit(0, cyc, 1'b0, 1'b1, '0, 1'b1, 1'b0, "async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_a[0] = 1'b0;

        // LATENCY=1 timing, and reset during RESP discards the write.
        xfer_start(1, 1'b0, 1'b1, 16'h0050, 128'h1234, a);
        add_lit(1, a + 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "l1_pre");
        add_lit(1, a + 2, 1'b1, 1'b0, '0, 1'b0, 1'b0, "l1_resp");
        add_lit(1, a + 3, 1'b0, 1'b0, '0, 1'b0, 1'b0, "l1_post");
        xfer_wait(1, 1'b0);
        xfer_start(1, 1'b1, 1'b0, 16'h0050, '0, a);
        add_lit(1, a + 2, 1'b1, 1'b1, 128'h1234, 1'b0, 1'b0, "l1_rd1234");
        xfer_wait(1, 1'b0);
        xfer_start(1, 1'b0, 1'b1, 16'h0050, 128'hBEEF, a);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_a[1] = 1'b1;
        wr_a[1]  = 1'b0;
        add_lit(1, a + 2, 1'b0, 1'b1, '0, 1'b1, 1'b0, "rst_in_resp");
        @(negedge clk);
        @(negedge clk);
        rst_a[1] = 1'b0;
        xfer_start(1, 1'b1, 1'b0, 16'h0050, '0, a);
        add_lit(1, a + 2, 1'b1, 1'b1, 128'h1234, 1'b0, 1'b0, "no_commit");
        xfer_wait(1, 1'b0);
        xfer_start(1, 1'b0, 1'b1, 16'h0050, 128'hCAFE, a);
        add_lit(1, a + 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "cafe_pre");
        add_lit(1, a + 2, 1'b1, 1'b0, '0, 1'b0, 1'b0, "cafe_resp");
        xfer_wait(1, 1'b0);
        xfer_start(1, 1'b1, 1'b0, 16'h0050, '0, a);
        add_lit(1, a + 2, 1'b1, 1'b1, 128'hCAFE, 1'b0, 1'b0, "cafe_rd");
        xfer_wait(1, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Line-granular physical-memory responder for the LC-3b memory system. It sits on the memory side of the cache's pmem interface and answers `pmem_read` / `pmem_write` requests with 128-bit lines after a fixed, parameterised latency, pulsing `pmem_resp` once per transaction. It serves as the synthesizable backing store and latency model for cache bring-up and for verifying the cache controller's miss, allocate and writeback paths.

## Interface
- `LATENCY`, default 8: cycles from request acceptance to `pmem_resp`. Legal values are 1..255.
- `IDX_W`, default 5: line-index width. Storage is 2^IDX_W lines of 128 bits.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `pmem_read` in 1: read-line request, held by the initiator until `pmem_resp`.
- `pmem_write` in 1: write-line request, held by the initiator until `pmem_resp`.
- `pmem_address` in 16 (`lc3b_word`): byte address. Bits [3:0] are ignored. The index is bits [IDX_W+3:4]. Higher bits alias.
- `pmem_wdata` in 128 (`lc3b_line`): write line, sampled at acceptance.
- `pmem_rdata` out 128 (`lc3b_line`): read line, valid while `pmem_resp` is high and held until the next read response.
- `pmem_resp` out 1: one-cycle completion pulse.
- `proto_err` out 1: sticky protocol-error flag.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - On an edge where `pmem_read | pmem_write` is high, latch the op, index and `pmem_wdata`. Load the counter with LATENCY-1 and move to WAIT.
  - If both `pmem_read` and `pmem_write` are high, the write wins and `proto_err` is set.
- **WAIT**
  - If the counter is 0, move to RESP. For reads, load `pmem_rdata` from the array at that same edge.
  - Otherwise decrement the counter.
  - Request inputs are ignored in WAIT. Deasserting a request does not cancel it: the transaction still completes and `pmem_resp` still pulses.
- **RESP**
  - `pmem_resp` is 1 for exactly this cycle.
  - A write commits to the array at the edge leaving RESP.
  - Next state is always IDLE.
- **Array and outputs**
  - Full-line writes only; there is no byte mask.
  - Array contents are not affected by reset. Reading a never-written line returns an undefined value; the bench must not check it.
  - `pmem_rdata` is unchanged by write transactions.
  - The counter width is 8 bits. It never wraps, because it is only decremented when nonzero.

## Timing
- Reset values: `pmem_resp`=0, `pmem_rdata`=128'h0, `proto_err`=0, state=IDLE, counter=0.
- Acceptance and response:
  - A request accepted at edge t puts `pmem_resp` high during the cycle [t+LATENCY, t+LATENCY+1).
  - With LATENCY=1, `pmem_resp` is high the cycle right after acceptance.
- Next request:
  - IDLE occupies the cycle after RESP. The earliest next acceptance is edge t+LATENCY+2.
  - So consecutive responses are at least LATENCY+2 cycles apart.
  - This lets the initiator change state on the `pmem_resp` edge and present its next request without it being double-accepted.
- Read-after-write to the same line, back-to-back, returns the new data. The write commits at t+LATENCY+1, before the read's array access.
- Reset asserted mid-transaction:
  - Outputs return to reset values immediately (asynchronous).
  - The pending write is discarded and no `pmem_resp` is produced.
  - After reset, an initiator request that is still held is accepted as a new transaction.

## Test plan
- **Reset:** assert `rst` mid-cycle.
  - `pmem_resp`, `pmem_rdata` and `proto_err` go to 0 without waiting for a clock edge.
- **Write then read, LATENCY=8:**
  - Write line 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to address 16'h0040, holding `pmem_write`. `pmem_resp` pulses exactly 8 cycles after acceptance, for 1 cycle.
  - Then read 16'h0047. `pmem_rdata` equals that line during the `pmem_resp` cycle.
- **Aliasing and back-to-back, IDX_W=5:**
  - Write 128'hAAAA…(all A) to 16'h0010, then immediately write 128'h5555…(all 5) to 16'h0210.
  - A read of 16'h0010 returns all 5s.
  - Acceptance edges are exactly LATENCY+2 apart.
- **Dropped request:**
  - Accept a write of 128'h1 to 16'h0020, then deassert `pmem_write` in WAIT. `pmem_resp` still pulses.
  - A later read of 16'h0020 returns 128'h1.
- **Protocol error:**
  - Assert read and write together with address 16'h0030 and data 128'hDEAD. `proto_err` rises and stays high.
  - A later read of 16'h0030 returns 128'hDEAD.
- **Reset mid-write, LATENCY=1:**
  - Write 128'hBEEF to 16'h0050 and assert `rst` in the RESP cycle before the commit edge. No commit occurs.
  - Write 128'hCAFE to the same address after reset, then read it back: returns 128'hCAFE.
  - Re-run the LATENCY=1 timing check: `pmem_resp` appears one cycle after acceptance.
